// File: rtl/mat_pkg.sv
// Shared constants and types for the skewed operand feeder of an N x N systolic array.
// Optional job counter in the top is controlled by MAT_FEEDER_STATS_EN.
package mat_pkg;

  localparam int unsigned DEF_N  = 4;
  localparam int unsigned DEF_K  = 4;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } feeder_state_t;

  // One inner-dimension slice at the default geometry: column k of A, row k of B.
  typedef struct packed {
    logic [DEF_N*DEF_DW-1:0] a;
    logic [DEF_N*DEF_DW-1:0] b;
  } slice_t;

endpackage

// File: rtl/mat_slice_buf.sv
// K-entry slice register file with one write port and N skewed read lanes for A and B.
// Lane l of both operands reads slot rd_t-l; out-of-window lanes read as zero.
module mat_slice_buf
  import mat_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned K  = DEF_K,
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = (K > 1) ? $clog2(K) : 1,
  parameter int unsigned TW = 4
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [N*DW-1:0]   wr_a,
  input  logic [N*DW-1:0]   wr_b,
  input  logic [TW-1:0]     rd_t,
  output logic [N*DW-1:0]   rd_a,
  output logic [N*DW-1:0]   rd_b
);

  logic [N*DW-1:0] mem_a [K];
  logic [N*DW-1:0] mem_b [K];
  logic [TW-1:0]   idx;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
    end
  end

  // Same-cycle write data is forwarded so the last slice can be read as it lands.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    idx  = '0;
    for (int unsigned l = 0; l < N; l++) begin
      idx = rd_t - TW'(l);
      if (rd_t >= TW'(l) && idx < TW'(K)) begin
        if (wr_en && wr_addr == AW'(idx)) begin
          rd_a[l*DW +: DW] = wr_a[l*DW +: DW];
          rd_b[l*DW +: DW] = wr_b[l*DW +: DW];
        end else begin
          rd_a[l*DW +: DW] = mem_a[AW'(idx)][l*DW +: DW];
          rd_b[l*DW +: DW] = mem_b[AW'(idx)][l*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/mat_skew_feeder.sv
// Buffers K slices of A/B, then streams them diagonally skewed into an N x N PE array.
// Define MAT_FEEDER_STATS_EN to add the 16-bit job_count output.
module mat_skew_feeder
  import mat_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned K  = DEF_K,
  parameter int unsigned DW = DEF_DW
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic [N*DW-1:0] a_west,
  output logic [N*DW-1:0] b_north,
  output logic            array_en,
  output logic            busy,
  output logic            done
`ifdef MAT_FEEDER_STATS_EN
  ,
  output logic [15:0]     job_count
`endif
);

  localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned TW = $clog2(K + 2*N);
  localparam logic [TW-1:0] LAST_T = TW'(K + 2*N - 3);

  feeder_state_t   state;
  logic [AW-1:0]   slice_cnt;
  logic [TW-1:0]   t;
  logic [TW-1:0]   rd_t;
  logic            wr_en;
  logic [N*DW-1:0] rd_a;
  logic [N*DW-1:0] rd_b;

  assign wr_en = in_valid && in_ready;

  // Outputs are registered, so the buffer is read one step ahead of the displayed t.
  assign rd_t = (state == ST_STREAM) ? t + TW'(1) : '0;

  mat_slice_buf #(
    .N  (N),
    .K  (K),
    .DW (DW),
    .AW (AW),
    .TW (TW)
  ) u_buf (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (slice_cnt),
    .wr_a    (in_a),
    .wr_b    (in_b),
    .rd_t    (rd_t),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= ST_IDLE;
      slice_cnt <= '0;
      t         <= '0;
      in_ready  <= 1'b0;
      array_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_west    <= '0;
      b_north   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            slice_cnt <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            slice_cnt <= slice_cnt + AW'(1);
            if (slice_cnt == AW'(K - 1)) begin
              state    <= ST_STREAM;
              t        <= '0;
              in_ready <= 1'b0;
              array_en <= 1'b1;
              a_west   <= rd_a;
              b_north  <= rd_b;
            end
          end
        end
        ST_STREAM: begin
          if (t == LAST_T) begin
            state    <= ST_DONE;
            array_en <= 1'b0;
            a_west   <= '0;
            b_north  <= '0;
            done     <= 1'b1;
          end else begin
            t       <= t + TW'(1);
            a_west  <= rd_a;
            b_north <= rd_b;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAT_FEEDER_STATS_EN
  always_ff @(posedge CLK) begin
    if (rst) begin
      job_count <= '0;
    end else if (done) begin
      job_count <= job_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mat_skew_feeder.sv
// Directed bench for mat_skew_feeder at N=4, K=4, DW=8 with a behavioural 4x4 PE grid.
// Stats checks are compiled in when MAT_FEEDER_STATS_EN is defined.
module tb_mat_skew_feeder;
  import mat_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned K  = 4;
  localparam int unsigned DW = 8;

  logic        CLK = 1'b0;
  logic        rst, start, in_valid, in_ready;
  logic [31:0] in_a, in_b, a_west, b_north;
  logic        array_en, busy, done;
`ifdef MAT_FEEDER_STATS_EN
  logic [15:0] job_count;
`endif

  always #5 CLK = ~CLK;

  mat_skew_feeder #(.N(N), .K(K), .DW(DW)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .a_west   (a_west),
    .b_north  (b_north),
    .array_en (array_en),
    .busy     (busy),
    .done     (done)
`ifdef MAT_FEEDER_STATS_EN
    ,
    .job_count(job_count)
`endif
  );

  typedef struct {
    int          t;
    logic [31:0] a;
    logic [31:0] b;
  } skew_vec_t;

  skew_vec_t  skew_tab [10];
  int         tests = 0;
  int         fails = 0;
  int         done_seen = 0;
  logic [7:0] A [4][4];
  logic [7:0] B [4][4];
  int         acc [4][4];
  logic [7:0] ar [4][4];
  logic [7:0] br [4][4];

  always @(negedge CLK) if (done) done_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pe_clear();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc[i][j] = 0;
        ar[i][j]  = '0;
        br[i][j]  = '0;
      end
  endtask

  // Output-stationary PE: a flows east, b flows south, one register per PE.
  task automatic pe_step();
    logic [7:0] na [4][4];
    logic [7:0] nb [4][4];
    logic [7:0] ai, bi;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ai = (j == 0) ? a_west[i*8 +: 8]  : ar[i][j-1];
        bi = (i == 0) ? b_north[j*8 +: 8] : br[i-1][j];
        acc[i][j] += int'(ai) * int'(bi);
        na[i][j] = ai;
        nb[i][j] = bi;
      end
    ar = na;
    br = nb;
  endtask

  task automatic slice_of(input int k, output logic [31:0] va, output logic [31:0] vb);
    slice_t s;
    for (int l = 0; l < 4; l++) begin
      s.a[l*8 +: 8] = A[l][k];
      s.b[l*8 +: 8] = B[k][l];
    end
    va = s.a;
    vb = s.b;
  endtask

  task automatic load_job(input bit gap, input bit glitch, input string tag);
    int budget;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " in_ready in LOAD"}, in_ready, 1);
    check({tag, " busy in LOAD"}, busy, 1);
    for (int k = 0; k < 4; k++) begin
      slice_of(k, in_a, in_b);
      in_valid = 1'b1;
      budget = 0;
      while (!in_ready && budget < 20) begin
        tick();
        budget++;
      end
      check({tag, " slice offered while ready"}, in_ready, 1);
      if (k == 3) check({tag, " no stream before last slice"}, array_en, 0);
      tick();
      in_valid = 1'b0;
      if (gap && k < 3) begin
        if (glitch && k == 1) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    check({tag, " stream starts after last slice"}, array_en, 1);
  endtask

  task automatic stream_job(input bit use_tab, input bit glitch, input string tag);
    int en_cycles;
    int exp_c;
    int d0;
    d0 = done_seen;
    pe_clear();
    en_cycles = 0;
    while (array_en && en_cycles < 40) begin
      if (use_tab && en_cycles < 10) begin
        check($sformatf("%s a_west t=%0d", tag, skew_tab[en_cycles].t), a_west, skew_tab[en_cycles].a);
        check($sformatf("%s b_north t=%0d", tag, skew_tab[en_cycles].t), b_north, skew_tab[en_cycles].b);
      end
      pe_step();
      en_cycles++;
      if (glitch && en_cycles == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check({tag, " array_en cycles"}, en_cycles, 10);
    check({tag, " done after stream"}, done, 1);
    check({tag, " a_west zero in DONE"}, a_west, 0);
    tick();
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy back low"}, busy, 0);
    tick();
    check({tag, " done pulses per job"}, done_seen - d0, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        exp_c = 0;
        for (int k = 0; k < 4; k++) exp_c += int'(A[i][k]) * int'(B[k][j]);
        check($sformatf("%s C[%0d][%0d]", tag, i, j), acc[i][j], exp_c);
      end
  endtask

  initial begin
    skew_tab[0] = '{0, 32'h0000_0000, 32'h0000_0080};
    skew_tab[1] = '{1, 32'h0000_1001, 32'h0000_8190};
    skew_tab[2] = '{2, 32'h0020_1102, 32'h0082_91A0};
    skew_tab[3] = '{3, 32'h3021_1203, 32'h8392_A1B0};
    skew_tab[4] = '{4, 32'h3122_1300, 32'h93A2_B100};
    skew_tab[5] = '{5, 32'h3223_0000, 32'hA3B2_0000};
    skew_tab[6] = '{6, 32'h3300_0000, 32'hB300_0000};
    skew_tab[7] = '{7, 32'h0000_0000, 32'h0000_0000};
    skew_tab[8] = '{8, 32'h0000_0000, 32'h0000_0000};
    skew_tab[9] = '{9, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    tick();
    tick();
    check("reset in_ready", in_ready, 0);
    check("reset array_en", array_en, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset a_west", a_west, 0);
    check("reset b_north", b_north, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    tick();
    check("idle ignores in_valid", in_ready, 0);
    in_valid = 1'b0;
    tick();

    // Identity A: product equals B.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = (i == j) ? 8'd1 : 8'd0;
        B[i][j] = 8'(i*4 + j + 1);
      end
    load_job(1'b0, 1'b0, "ident");
    stream_job(1'b0, 1'b0, "ident");
    check("ident C[2][3] equals B", acc[2][3], int'(B[2][3]));

    // Skew pattern, slices offered on alternate cycles.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 8'(8'h10*i + j);
        B[i][j] = 8'(8'h80 | (i << 4) | j);
      end
    load_job(1'b1, 1'b0, "skew");
    stream_job(1'b1, 1'b0, "skew");

    // Start pulses during LOAD and STREAM must be ignored.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 8'($urandom_range(255));
        B[i][j] = 8'($urandom_range(255));
      end
    load_job(1'b1, 1'b1, "glitch");
    stream_job(1'b0, 1'b1, "glitch");

    // Reset in the middle of STREAM at t=5.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 8'(8'h10*i + j);
        B[i][j] = 8'(8'h80 | (i << 4) | j);
      end
    load_job(1'b0, 1'b0, "midrst");
    for (int s = 0; s < 5; s++) tick();
    check("midrst a_west at t=5", a_west, skew_tab[5].a);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst array_en", array_en, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 0);
    check("midrst done", done, 0);
    check("midrst a_west", a_west, 0);
    check("midrst b_north", b_north, 0);
    tick();

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 8'(3*i + j + 2);
        B[i][j] = 8'(5*i + 7*j + 1);
      end
    load_job(1'b0, 1'b0, "fresh");
    stream_job(1'b0, 1'b0, "fresh");

`ifdef MAT_FEEDER_STATS_EN
    load_job(1'b0, 1'b0, "stats2");
    stream_job(1'b0, 1'b0, "stats2");
    load_job(1'b0, 1'b0, "stats3");
    stream_job(1'b0, 1'b0, "stats3");
    check("job_count after 3 jobs", job_count, 3);
    force dut.job_count = 16'hFFFF;
    tick();
    release dut.job_count;
    check("job_count preload", job_count, 16'hFFFF);
    load_job(1'b0, 1'b0, "wrap");
    stream_job(1'b0, 1'b0, "wrap");
    check("job_count wraps", job_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
